// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file: address byte, pointer byte, then write bytes or read bytes.
// Latency: bus sampled through p_sync_stages flops plus an edge flop; o_dbg_data is one cycle behind i_dbg_addr.
// Never stretches SCL, so there is no backpressure. Define I2C_TARGET_AUTOINC_EN for pointer auto-increment and a reset-cleared file.
module i2c_target_regfile #(
    parameter logic [6:0] p_slave_addr  = 7'h21,
    parameter int         p_addr_width  = 8,
    parameter int         p_sync_stages = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_scl,
    input  logic                    i_sda,
    output logic                    o_sda_low,
    output logic                    o_wr_valid,
    output logic [p_addr_width-1:0] o_wr_addr,
    output logic [7:0]              o_wr_data,
    input  logic [p_addr_width-1:0] i_dbg_addr,
    output logic [7:0]              o_dbg_data,
    output logic                    o_busy
);
    localparam int c_depth = 2 ** p_addr_width;
`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit c_autoinc = 1'b1;
`else
    localparam bit c_autoinc = 1'b0;
`endif

    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK} state_t;

    logic [p_sync_stages-1:0] scl_ff, sda_ff;
    logic                     scl_prev, sda_prev;
    logic                     scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [7:0]              sh, sh_n, shifted;
    logic [p_addr_width-1:0] ptr, ptr_n, ptr_adv;
    logic                    rw, rw_n, ack_seen, ack_seen_n, sda_low_n, busy_n;
    logic                    wr_valid_n;
    logic [p_addr_width-1:0] wr_addr_n;
    logic [7:0]              wr_data_n;
    logic                    mem_we;
    logic [7:0]              mem [c_depth];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_ff   <= '1;
            sda_ff   <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_ff   <= {scl_ff[p_sync_stages-2:0], i_scl};
            sda_ff   <= {sda_ff[p_sync_stages-2:0], i_sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s     = scl_ff[p_sync_stages-1];
    assign sda_s     = sda_ff[p_sync_stages-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    assign shifted   = {sh[6:0], sda_s};
    assign ptr_adv   = c_autoinc ? ptr + 1'b1 : ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            sh         <= 8'h00;
            ptr        <= '0;
            rw         <= 1'b0;
            ack_seen   <= 1'b0;
            o_sda_low  <= 1'b0;
            o_busy     <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= 8'h00;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            ptr        <= ptr_n;
            rw         <= rw_n;
            ack_seen   <= ack_seen_n;
            o_sda_low  <= sda_low_n;
            o_busy     <= busy_n;
            o_wr_valid <= wr_valid_n;
            o_wr_addr  <= wr_addr_n;
            o_wr_data  <= wr_data_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sh_n       = sh;
        ptr_n      = ptr;
        rw_n       = rw;
        ack_seen_n = ack_seen;
        sda_low_n  = o_sda_low;
        busy_n     = o_busy;
        wr_valid_n = 1'b0;
        wr_addr_n  = o_wr_addr;
        wr_data_n  = o_wr_data;
        mem_we     = 1'b0;
        // Bus conditions outrank any bit activity, so a STOP mid-byte never commits a write.
        if (stop_det) begin
            state_n    = IDLE;
            cnt_n      = 4'd0;
            sda_low_n  = 1'b0;
            busy_n     = 1'b0;
            ack_seen_n = 1'b0;
        end else if (start_det) begin
            state_n    = ADDR;
            cnt_n      = 4'd0;
            sda_low_n  = 1'b0;
            ack_seen_n = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR, PTR, WDATA: if (scl_rise) begin
                    sh_n  = shifted;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n = 4'd0;
                        if (state == ADDR) begin
                            if (shifted[7:1] == p_slave_addr) begin
                                state_n = ADDR_ACK;
                                rw_n    = shifted[0];
                                busy_n  = 1'b1;
                            end else begin
                                state_n   = IDLE;
                                busy_n    = 1'b0;
                                sda_low_n = 1'b0;
                            end
                        end else if (state == PTR) begin
                            ptr_n   = p_addr_width'(shifted);
                            state_n = PTR_ACK;
                        end else begin
                            mem_we     = 1'b1;
                            wr_valid_n = 1'b1;
                            wr_addr_n  = ptr;
                            wr_data_n  = shifted;
                            ptr_n      = ptr_adv;
                            state_n    = WACK;
                        end
                    end
                end
                // First SCL fall pulls SDA, the next one ends the ACK slot.
                ADDR_ACK, PTR_ACK, WACK: if (scl_fall) begin
                    if (!o_sda_low) begin
                        sda_low_n = 1'b1;
                    end else if (state == ADDR_ACK && rw) begin
                        state_n   = RDATA;
                        cnt_n     = 4'd0;
                        sh_n      = mem[ptr];
                        sda_low_n = ~mem[ptr][7];
                    end else begin
                        state_n   = (state == ADDR_ACK) ? PTR : WDATA;
                        cnt_n     = 4'd0;
                        sda_low_n = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            state_n    = RACK;
                            cnt_n      = 4'd0;
                            sda_low_n  = 1'b0;
                            ack_seen_n = 1'b0;
                        end else begin
                            sh_n      = {sh[6:0], 1'b0};
                            sda_low_n = ~sh[6];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ack_seen_n = 1'b1;
                            ptr_n      = ptr_adv;
                            sh_n       = mem[ptr_adv];
                        end else begin
                            state_n   = IDLE;
                            sda_low_n = 1'b0;
                        end
                    end else if (scl_fall && ack_seen) begin
                        state_n    = RDATA;
                        cnt_n      = 4'd0;
                        ack_seen_n = 1'b0;
                        sda_low_n  = ~sh[7];
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef I2C_TARGET_AUTOINC_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_depth; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[ptr] <= shifted;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[ptr] <= shifted;
    end
`endif

    always_ff @(posedge i_clk) begin
        o_dbg_data <= mem[i_dbg_addr];
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: an open-drain I2C controller model drives the target and checks ACKs, writes, reads and reset.
module tb_i2c_target_regfile;
    localparam int Q = 10;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] i_dbg_addr = 8'h00;
    logic       o_sda_low, o_wr_valid, o_busy;
    logic [7:0] o_wr_addr, o_wr_data, o_dbg_data;
    wire        sda_bus = m_sda & ~o_sda_low;

    int          checks = 0;
    int          failures = 0;
    int          low_cnt = 0;
    int          busy_cnt = 0;
    logic [15:0] wlog[$];

    always #5 i_clk = ~i_clk;

    i2c_target_regfile dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (m_scl),
        .i_sda      (sda_bus),
        .o_sda_low  (o_sda_low),
        .o_wr_valid (o_wr_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data),
        .o_busy     (o_busy)
    );

    always @(negedge i_clk) begin
        if (o_sda_low) low_cnt++;
        if (o_busy) busy_cnt++;
        if (o_wr_valid) wlog.push_back({o_wr_addr, o_wr_data});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(2*Q);
        m_sda = 1'b0; tick(2*Q); m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(2*Q);
        m_sda = 1'b1; tick(2*Q);
    endtask

    task automatic sbit(input logic b, output logic s);
        m_sda = b; tick(Q); m_scl = 1'b1; tick(Q);
        s = sda_bus; tick(Q); m_scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) sbit(d[i], s);
        sbit(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sbit(1'b1, s);
            d[i] = s;
        end
        sbit(nack, s);
    endtask

    task automatic dbg_read(input logic [7:0] a, output logic [7:0] d);
        i_dbg_addr = a; tick(2); d = o_dbg_data;
    endtask

    task automatic write_txn(input string tag, input logic [7:0] reg_addr, input logic [7:0] data);
        logic a0, a1, a2;
        int   base;
        base = wlog.size();
        bus_start();
        send_byte(8'h42, a0);
        send_byte(reg_addr, a1);
        send_byte(data, a2);
        bus_stop();
        check_eq({tag, "_acks"}, {a0, a1, a2}, 3'b000);
        check_eq({tag, "_wr_count"}, wlog.size() - base, 1);
        if (wlog.size() > base) check_eq({tag, "_wr_log"}, wlog[base], {reg_addr, data});
    endtask

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] d0, d1, a8;
        int         base, lsnap, bsnap;

        tick(4);
        check_eq("rst_sda_low", o_sda_low, 1'b0);
        check_eq("rst_wr_valid", o_wr_valid, 1'b0);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_wr_addr", o_wr_addr, 8'h00);
        check_eq("rst_wr_data", o_wr_data, 8'h00);
        i_rst_n = 1'b1;
        tick(4);

        // Basic write of 0x55 to 0x1E, busy while addressed
        base = wlog.size();
        bus_start();
        send_byte(8'h42, a0);
        check_eq("t1_busy_after_addr", o_busy, 1'b1);
        send_byte(8'h1E, a1);
        send_byte(8'h55, a2);
        bus_stop();
        check_eq("t1_acks", {a0, a1, a2}, 3'b000);
        check_eq("t1_wr_count", wlog.size() - base, 1);
        if (wlog.size() > base) check_eq("t1_wr_log", wlog[base], 16'h1E55);
        check_eq("t1_busy_after_stop", o_busy, 1'b0);
        dbg_read(8'h1E, d0);
        check_eq("t1_dbg_1e", d0, 8'h55);

        write_txn("t2", 8'h1F, 8'h56);
        dbg_read(8'h1F, d0);
        check_eq("t2_dbg_1f", d0, 8'h56);

`ifdef I2C_TARGET_AUTOINC_EN
        base = wlog.size();
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'hFF, a1);
        send_byte(8'hA1, a2);
        send_byte(8'hA2, a3);
        bus_stop();
        check_eq("wrap_acks", {a0, a1, a2, a3}, 4'b0000);
        check_eq("wrap_wr_count", wlog.size() - base, 2);
        if (wlog.size() > base + 1) begin
            check_eq("wrap_wr0", wlog[base], 16'hFFA1);
            check_eq("wrap_wr1", wlog[base+1], 16'h00A2);
        end
`endif

        // Wrong address: no ACK, no busy, no write
        base = wlog.size(); lsnap = low_cnt; bsnap = busy_cnt;
        bus_start();
        send_byte(8'h44, a0);
        send_byte(8'h1E, a1);
        bus_stop();
        check_eq("t3_nack", a0, 1'b1);
        check_eq("t3_sda_never_low", low_cnt - lsnap, 0);
        check_eq("t3_busy_never", busy_cnt - bsnap, 0);
        check_eq("t3_no_write", wlog.size() - base, 0);

        // Pointer set, repeated START, read two bytes
        base = wlog.size();
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'h1E, a1);
        bus_start();
        send_byte(8'h43, a2);
        recv_byte(d0, 1'b0);
        recv_byte(d1, 1'b1);
        check_eq("t4_sda_released", o_sda_low, 1'b0);
        bus_stop();
        check_eq("t4_acks", {a0, a1, a2}, 3'b000);
        check_eq("t4_rd0", d0, 8'h55);
`ifdef I2C_TARGET_AUTOINC_EN
        check_eq("t4_rd1", d1, 8'h56);
`else
        check_eq("t4_rd1", d1, 8'h55);
`endif
        check_eq("t4_no_write", wlog.size() - base, 0);

        // STOP after 4 data bits aborts the byte
        base = wlog.size();
        bus_start();
        send_byte(8'h42, a0);
        send_byte(8'h10, a1);
        for (int i = 0; i < 4; i++) sbit(i[0], a2);
        bus_stop();
        check_eq("t5_no_write", wlog.size() - base, 0);
        check_eq("t5_busy", o_busy, 1'b0);
        write_txn("t5_next", 8'h10, 8'h77);
        dbg_read(8'h10, d0);
        check_eq("t5_dbg_10", d0, 8'h77);

        // Reset while the target drives the address ACK
        a8 = 8'h42;
        bus_start();
        for (int i = 7; i >= 0; i--) sbit(a8[i], a0);
        m_sda = 1'b1;
        tick(Q);
        check_eq("t6_ack_driven", o_sda_low, 1'b1);
        i_rst_n = 1'b0;
        #1;
        check_eq("t6_rst_sda_low", o_sda_low, 1'b0);
        check_eq("t6_rst_busy", o_busy, 1'b0);
        check_eq("t6_rst_wr_valid", o_wr_valid, 1'b0);
        check_eq("t6_rst_wr_addr", o_wr_addr, 8'h00);
        check_eq("t6_rst_wr_data", o_wr_data, 8'h00);
        tick(3);
        i_rst_n = 1'b1;
        m_scl = 1'b1; tick(2*Q); m_scl = 1'b0; tick(Q);
        check_eq("t6_sda_after_rst", o_sda_low, 1'b0);
        bus_stop();
        write_txn("t6_next", 8'h20, 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter p_slave_addr, default 7'h21, giving the 7-bit target address to match.
REQ-002 SHALL have parameter p_addr_width, default 8, giving the register pointer width; the file holds 2**p_addr_width bytes.
REQ-003 SHALL have parameter p_sync_stages, default 2, giving the synchronizer depth on SCL/SDA (minimum 2).
REQ-004 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_scl, input, 1 bit: bus SCL, asynchronous to i_clk.
REQ-007 SHALL have port i_sda, input, 1 bit: bus SDA, asynchronous to i_clk.
REQ-008 SHALL have port o_sda_low, output, 1 bit: 1 pulls SDA low (open-drain); the top ties SDA to the pad as 0 when set, else Z.
REQ-009 SHALL have port o_wr_valid, output, 1 bit: one-cycle strobe per register byte written.
REQ-010 SHALL have port o_wr_addr, output, p_addr_width bits: the register address written.
REQ-011 SHALL have port o_wr_data, output, 8 bits: the byte written.
REQ-012 SHALL have port i_dbg_addr, input, p_addr_width bits: host-side read address.
REQ-013 SHALL have port o_dbg_data, output, 8 bits: register contents at i_dbg_addr, registered with 1-cycle latency.
REQ-014 SHALL have port o_busy, output, 1 bit: high from address match until STOP or a non-matching START.

Function
REQ-015 SHALL pass SCL and SDA through p_sync_stages flops, then detect edges by comparing with the previous synchronized value.
REQ-016 SHALL detect START as a synchronized SDA fall while SCL is high, and STOP as an SDA rise while SCL is high; both are honoured in every state.
REQ-017 SHALL sample SDA on the synchronized SCL rise, and change o_sda_low only on the synchronized SCL fall.
REQ-018 SHALL use FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK.
REQ-019 SHALL handle START (including repeated START) as follows: go to ADDR, clear the bit counter, release SDA.
REQ-020 SHALL handle ADDR as follows: shift in 8 bits MSB-first; on an address match go to ADDR_ACK, otherwise go to IDLE with SDA released.
REQ-021 SHALL handle ADDR_ACK as follows: drive SDA low for one SCL period; then go to PTR if R/W=0, or go to RDATA if R/W=1 with the byte at the pointer loaded into the shift register.
REQ-022 SHALL handle PTR as follows: shift in 8 bits, load the pointer from the low p_addr_width bits, ACK in PTR_ACK, then go to WDATA.
REQ-023 SHALL handle WDATA as follows: shift in 8 bits; on the 8th SCL rise, write the file, pulse o_wr_valid exactly once with o_wr_addr=pointer, and ACK in WACK.
REQ-024 SHALL handle RDATA as follows: drive the shift register MSB-first, releasing SDA for 1 bits; in RACK sample the controller's ACK.
REQ-025 SHALL, on ACK=0 in RACK, advance the pointer, load the next byte and return to RDATA.
REQ-026 SHALL, on NACK in RACK, release SDA and go to IDLE.
REQ-027 SHALL wrap the pointer from 2**p_addr_width-1 to 0.
REQ-028 SHALL give STOP priority over a bit sample in the same cycle, and SHALL not write a partial byte.
REQ-029 SHALL support SCL periods of at least 8*(p_sync_stages+2) i_clk cycles; slower buses are unconstrained.
REQ-030 SHALL never stretch the clock.

Reset
REQ-031 SHALL, while i_rst_n=0, asynchronously set: state IDLE, o_sda_low=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0, pointer=0, synchronizer flops=1.
REQ-032 SHALL leave register file contents undefined after reset, except under REQ-035.
REQ-033 SHALL, when reset is asserted mid-transfer, release SDA within the same cycle; the transfer resumes only after a new START.

Configuration
REQ-034 SHALL support macro I2C_TARGET_AUTOINC_EN.
REQ-035 SHALL, with I2C_TARGET_AUTOINC_EN defined: advance the pointer after each WDATA byte and each acked RDATA byte, with wrap per REQ-027, and clear the file to 0x00 by reset.
REQ-036 SHALL, without I2C_TARGET_AUTOINC_EN: keep the pointer fixed for the whole transaction (every byte accesses the same register, SCCB style) and build the file without reset.

Verification
REQ-037 SHALL cover: START, 0x42, 0x1E, 0x55, STOP -> three ACKs; one o_wr_valid with addr 0x1E, data 0x55; o_dbg_data=0x55 at 0x1E.
REQ-038 SHALL cover: START, 0x44 (wrong address) -> SDA never pulled low; o_busy stays 0; no write.
REQ-039 SHALL cover (AUTOINC_EN): START, 0x42, 0xFF, 0xA1, 0xA2, STOP -> writes 0xFF=0xA1 then 0x00=0xA2 (wrap).
REQ-040 SHALL cover: START, 0x42, 0x1E, repeated START, 0x43, read 2 bytes (ACK then NACK) -> 0x55, then 0x56-contents with AUTOINC (0x55 again without it); SDA released after the NACK.
REQ-041 SHALL cover: STOP injected after 4 data bits of WDATA -> no o_wr_valid; state IDLE; the next transaction works normally.
REQ-042 SHALL cover: i_rst_n pulsed low while the block drives ACK -> o_sda_low=0 in the same cycle; all outputs at their reset values.
